// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display paths: blank/dash patterns and
// digit positions (0 = sec_1 .. 5 = hr_10).
package seg_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [2:0] {
        SEC_1  = 3'd0,
        SEC_10 = 3'd1,
        MIN_1  = 3'd2,
        MIN_10 = 3'd3,
        HR_1   = 3'd4,
        HR_10  = 3'd5
    } digit_idx_t;

endpackage

// File: rtl/bcd_to_seg.sv
// BCD to active-low 7-segment decoder, segment order {g,f,e,d,c,b,a}.
// Non-decimal codes 10-15 show a dash so corrupt digits are visible on the board.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed 6-digit common-anode driver with guard interval and cursor blink.
// Optional build macro LEADING_ZERO_BLANK_EN blanks a zero hr_10 outside its edit.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SCAN_HZ   = 1000,
    parameter int BLINK_HZ  = 2,
    parameter int GUARD_CYC = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hr_10,
    input  logic [3:0] hr_1,
    input  logic [3:0] min_10,
    input  logic [3:0] min_1,
    input  logic [3:0] sec_10,
    input  logic [3:0] sec_1,
    input  logic       edit_en,
    input  logic [2:0] cursor,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int DWELL = CLK_HZ / SCAN_HZ;
    localparam int HALF  = CLK_HZ / (2 * BLINK_HZ);
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int BL_W  = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [DW_W-1:0] GUARD_END  = DW_W'(GUARD_CYC);
    localparam logic [BL_W-1:0] HALF_LAST  = BL_W'(HALF - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    logic [DW_W-1:0] dwell_cnt_p0;
    logic [2:0]      idx_p0;
    logic [BL_W-1:0] blink_cnt_p0;
    logic            blink_phase_p0;

    logic [3:0]            digit_sel;
    logic [6:0]            seg_dec;
    logic                  guard;
    logic                  cur_blank;
    logic                  lz_blank;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;

    logic [NUM_DIGITS-1:0] an_p1;
    logic [6:0]            seg_p1;
    logic                  dp_p1;

    // Stage p0: free-running scan and blink timebases
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_cnt_p0   <= '0;
            idx_p0         <= SEC_1;
            blink_cnt_p0   <= '0;
            blink_phase_p0 <= 1'b0;
        end else begin
            if (dwell_cnt_p0 == DWELL_LAST) begin
                dwell_cnt_p0 <= '0;
                idx_p0       <= (idx_p0 == HR_10) ? SEC_1 : idx_p0 + 3'd1;
            end else begin
                dwell_cnt_p0 <= dwell_cnt_p0 + 1'b1;
            end

            if (blink_cnt_p0 == HALF_LAST) begin
                blink_cnt_p0   <= '0;
                blink_phase_p0 <= ~blink_phase_p0;
            end else begin
                blink_cnt_p0 <= blink_cnt_p0 + 1'b1;
            end
        end
    end

    always_comb begin
        digit_sel = 4'd0;
        case (idx_p0)
            SEC_1:   digit_sel = sec_1;
            SEC_10:  digit_sel = sec_10;
            MIN_1:   digit_sel = min_1;
            MIN_10:  digit_sel = min_10;
            HR_1:    digit_sel = hr_1;
            HR_10:   digit_sel = hr_10;
            default: digit_sel = 4'd0;
        endcase
    end

    bcd_to_seg u_dec (
        .bcd (digit_sel),
        .seg (seg_dec)
    );

    always_comb begin
        guard     = (dwell_cnt_p0 < GUARD_END);
        // cursor 6-7 never matches idx, so an invalid cursor blanks nothing
        cur_blank = edit_en && blink_phase_p0 && (idx_p0 == cursor);
`ifdef LEADING_ZERO_BLANK_EN
        lz_blank  = (idx_p0 == HR_10) && (hr_10 == 4'd0) &&
                    !(edit_en && (cursor == HR_10));
`else
        lz_blank  = 1'b0;
`endif
        an_nxt  = guard ? AN_OFF : ~(AN_ONE << idx_p0);
        seg_nxt = (guard || cur_blank || lz_blank) ? SEG_BLANK : seg_dec;
        dp_nxt  = !(!guard && !cur_blank && (idx_p0 == HR_1 || idx_p0 == MIN_1));
    end

    // Stage p1: registered pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_p1  <= AN_OFF;
            seg_p1 <= SEG_BLANK;
            dp_p1  <= 1'b1;
        end else begin
            an_p1  <= an_nxt;
            seg_p1 <= seg_nxt;
            dp_p1  <= dp_nxt;
        end
    end

    assign an  = an_p1;
    assign seg = seg_p1;
    assign dp  = dp_p1;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display at DWELL=12, HALF=60, GUARD_CYC=2.
// Honours LEADING_ZERO_BLANK_EN when the build defines it.
module tb_seg_scan_display;

    logic       clk;
    logic       reset;
    logic [3:0] hr_10, hr_1, min_10, min_1, sec_10, sec_1;
    logic       edit_en;
    logic [2:0] cursor;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks;
    int failures;
    int k;

    logic [6:0] seg_tab [6];
    logic [5:0] exp_an;
    logic [6:0] exp_sg;
    logic       exp_dp;

    seg_scan_display #(
        .CLK_HZ    (1200),
        .SCAN_HZ   (100),
        .BLINK_HZ  (10),
        .GUARD_CYC (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .hr_10   (hr_10),
        .hr_1    (hr_1),
        .min_10  (min_10),
        .min_1   (min_1),
        .sec_10  (sec_10),
        .sec_1   (sec_1),
        .edit_en (edit_en),
        .cursor  (cursor),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and work out what the pins must show after edge k.
    // Edge k reflects dwell count (k-1)%12, idx ((k-1)/12)%6, blink phase ((k-1)/60)%2.
    task automatic tick();
        int c, i, ph;
        logic blank;
        logic [5:0] one6;
        @(posedge clk);
        #1;
        k++;
        c  = (k - 1) % 12;
        i  = ((k - 1) / 12) % 6;
        ph = ((k - 1) / 60) % 2;
        one6 = 6'b000001;
        if (c < 2) begin
            exp_an = 6'h3F;
            exp_sg = 7'h7F;
            exp_dp = 1'b1;
        end else begin
            exp_an = ~(one6 << i);
            blank  = edit_en && (ph == 1) && (int'(cursor) == i);
            exp_sg = blank ? 7'h7F : seg_tab[i];
`ifdef LEADING_ZERO_BLANK_EN
            if (i == 5 && hr_10 == 4'd0 && !(edit_en && cursor == 3'd5))
                exp_sg = 7'h7F;
`endif
            exp_dp = (!blank && (i == 2 || i == 4)) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        k = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (an !== 6'h3F || seg !== 7'h7F || dp !== 1'b1) begin
            failures++;
            $display("FAIL reset_values an=%h seg=%h dp=%b required an=3f seg=7f dp=1", an, seg, dp);
        end
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        repeat (2) tick();
        checks++;
        if (an !== 6'h3F || seg !== 7'h7F) begin
            failures++;
            $display("FAIL reset_guard an=%h seg=%h required an=3f seg=7f", an, seg);
        end
        tick();
        checks++;
        if (an !== 6'h3E || seg !== 7'h02 || dp !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_active an=%h seg=%h dp=%b required an=3e seg=02 dp=1", an, seg, dp);
        end
    endtask

    task automatic test_scan();
        {hr_10, hr_1, min_10, min_1, sec_10, sec_1} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        edit_en = 1'b0;
        cursor  = 3'd0;
        seg_tab = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
        apply_reset();
        for (int j = 0; j < 144; j++) begin
            tick();
            checks++;
            if (an !== exp_an || seg !== exp_sg || dp !== exp_dp) begin
                failures++;
                $display("FAIL scan k=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                         k, an, seg, dp, exp_an, exp_sg, exp_dp);
            end
        end
    endtask

    task automatic test_cursor_blink();
        {hr_10, hr_1, min_10, min_1, sec_10, sec_1} = {4'd1, 4'd2, 4'd5, 4'd4, 4'd5, 4'd6};
        seg_tab = '{7'h02, 7'h12, 7'h19, 7'h12, 7'h24, 7'h79};
        edit_en = 1'b1;
        cursor  = 3'd3;
        apply_reset();
        for (int j = 0; j < 360; j++) begin
            tick();
            checks++;
            if (an !== exp_an || seg !== exp_sg || dp !== exp_dp) begin
                failures++;
                $display("FAIL blink_c3 k=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                         k, an, seg, dp, exp_an, exp_sg, exp_dp);
            end
        end
        // Cursor on a separator digit: blanking also suppresses its dp
        cursor = 3'd4;
        for (int j = 0; j < 144; j++) begin
            tick();
            checks++;
            if (an !== exp_an || seg !== exp_sg || dp !== exp_dp) begin
                failures++;
                $display("FAIL blink_c4 k=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                         k, an, seg, dp, exp_an, exp_sg, exp_dp);
            end
        end
        cursor = 3'd7;
        for (int j = 0; j < 144; j++) begin
            tick();
            checks++;
            if (an !== exp_an || seg !== exp_sg || dp !== exp_dp) begin
                failures++;
                $display("FAIL blink_c7 k=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                         k, an, seg, dp, exp_an, exp_sg, exp_dp);
            end
        end
        edit_en = 1'b0;
    endtask

    task automatic test_invalid_bcd();
        {hr_10, hr_1, min_10, min_1, sec_10, sec_1} = {4'd1, 4'd2, 4'd3, 4'd4, 4'hC, 4'd6};
        seg_tab = '{7'h02, 7'h3F, 7'h19, 7'h30, 7'h24, 7'h79};
        edit_en = 1'b0;
        apply_reset();
        for (int j = 0; j < 36; j++) begin
            tick();
            checks++;
            if (an !== exp_an || seg !== exp_sg || dp !== exp_dp) begin
                failures++;
                $display("FAIL invalid_bcd k=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                         k, an, seg, dp, exp_an, exp_sg, exp_dp);
            end
        end
    endtask

    task automatic test_async_reset();
        {hr_10, hr_1, min_10, min_1, sec_10, sec_1} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        seg_tab = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
        edit_en = 1'b0;
        apply_reset();
        repeat (43) tick();
        checks++;
        if (an !== 6'h37 || seg !== 7'h30) begin
            failures++;
            $display("FAIL mid_dwell_idx3 an=%h seg=%h required an=37 seg=30", an, seg);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (an !== 6'h3F || seg !== 7'h7F || dp !== 1'b1) begin
            failures++;
            $display("FAIL async_reset an=%h seg=%h dp=%b required an=3f seg=7f dp=1", an, seg, dp);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        for (int j = 0; j < 24; j++) begin
            tick();
            checks++;
            if (an !== exp_an || seg !== exp_sg || dp !== exp_dp) begin
                failures++;
                $display("FAIL post_reset k=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                         k, an, seg, dp, exp_an, exp_sg, exp_dp);
            end
        end
    endtask

    task automatic test_leading_zero();
        {hr_10, hr_1, min_10, min_1, sec_10, sec_1} = {4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        seg_tab = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h40};
        edit_en = 1'b0;
        cursor  = 3'd0;
        apply_reset();
        for (int j = 0; j < 72; j++) begin
            tick();
            checks++;
            if (an !== exp_an || seg !== exp_sg || dp !== exp_dp) begin
                failures++;
                $display("FAIL lz_view k=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                         k, an, seg, dp, exp_an, exp_sg, exp_dp);
            end
        end
        edit_en = 1'b1;
        cursor  = 3'd5;
        apply_reset();
        for (int j = 0; j < 288; j++) begin
            tick();
            checks++;
            if (an !== exp_an || seg !== exp_sg || dp !== exp_dp) begin
                failures++;
                $display("FAIL lz_edit k=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                         k, an, seg, dp, exp_an, exp_sg, exp_dp);
            end
        end
        edit_en = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        k        = 0;
        reset    = 1'b1;
        edit_en  = 1'b0;
        cursor   = 3'd0;
        {hr_10, hr_1, min_10, min_1, sec_10, sec_1} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        seg_tab = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};

        test_reset();
        test_scan();
        test_cursor_blink();
        test_invalid_bcd();
        test_async_reset();
        test_leading_zero();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Time-multiplexed 6-digit 7-segment driver. Sits directly downstream of the countdown/clock cores and consumes their six BCD digits (hr_10..sec_1).
- Scans one digit at a time with an anti-ghosting guard interval.
- Blinks the digit under the edit cursor while the user sets a time with left/right/up/down.
- Drives active-low common-anode board pins.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency.
- SCAN_HZ, 1000, per-digit dwell rate; dwell = CLK_HZ/SCAN_HZ cycles.
- BLINK_HZ, 2, cursor blink rate; half-period = CLK_HZ/(2*BLINK_HZ) cycles.
- GUARD_CYC, 16, all-anodes-off cycles at the start of each dwell; must be < CLK_HZ/SCAN_HZ.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- hr_10, hr_1, min_10, min_1, sec_10, sec_1  in  4 each  BCD digits
- edit_en  in  1  1 = edit mode, cursor digit blinks
- cursor  in  3  digit index under edit (0 = sec_1 .. 5 = hr_10)
- an  out  6  active-low anode enables; an[i] drives digit i (0 = sec_1, 5 = hr_10)
- seg  out  7  active-low segments {g,f,e,d,c,b,a}
- dp  out  1  active-low decimal point

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high.
- Reset values: an=6'b111111, seg=7'h7F, dp=1, digit index idx=0, dwell counter=0, blink counter=0, blink_phase=0.
- Dwell counter:
  - Counts 0..DWELL-1, where DWELL = CLK_HZ/SCAN_HZ.
  - At DWELL-1 it wraps to 0 and idx advances; 5 wraps to 0.
- Guard interval: while dwell counter < GUARD_CYC, an=6'b111111 and seg=7'h7F (blank).
- Active dwell: otherwise an = ~(1<<idx) and seg = decode(digit[idx]).
- Registering: all outputs are registered, with one cycle of latency from counter/idx state to pins. Digit inputs are sampled each cycle with no input latching, so a digit change shows on the next active cycle of that digit.
- Decode:
  - 0-9 give standard patterns, e.g. 0=7'h40, 1=7'h79, 8=7'h00.
  - Values 10-15 give a dash (only g lit, 7'h3F).
- Blink counter:
  - Counts 0..HALF-1, where HALF = CLK_HZ/(2*BLINK_HZ).
  - At wrap it toggles blink_phase.
  - It runs freely regardless of edit_en.
- Cursor blank: if edit_en=1, blink_phase=1 and idx==cursor, then seg=7'h7F and dp=1. The anode still follows the normal scan, so scan timing is unchanged.
- Invalid cursor: cursor values 6-7 blank no digit.
- Decimal point: dp=0 during the active dwell of idx 4 (hr_1) and idx 2 (min_1), as separators. dp=1 otherwise, including during the guard interval.
- edit_en changes: take effect on the next cycle. blink_phase is not reset, so blinking may start in the off phase.
- Reset mid-scan: all outputs return to reset values immediately (asynchronously). After reset release, the scan restarts at idx 0 with a full guard interval.
- Simultaneous events: the dwell wrap and the blink wrap in the same cycle are both applied. The blank decision uses the new idx and new blink_phase on the following cycle.

Optional Feature:
- LEADING_ZERO_BLANK_EN, when defined:
  - Digit 5 (hr_10) is blanked (seg=7'h7F) whenever hr_10==0, except in edit mode when cursor==5, so the user can see the digit being set.
  - The dp behaviour is unchanged.
- When undefined: hr_10=0 displays "0" like any other digit.

Decomposition:
- Shared package seg_pkg:
  - SEG_BLANK=7'h7F, SEG_DASH=7'h3F.
  - NUM_DIGITS=6.
  - The digit index constants SEC_1..HR_10.
- One sub-module, bcd_to_seg: purely combinational, 4-bit in, 7-bit active-low out, dash for values >9. It is reusable by the other display paths on the board.

Test Plan:
- Bench parameters for all scenarios: CLK_HZ=1200, SCAN_HZ=100 (DWELL=12), BLINK_HZ=10 (HALF=60), GUARD_CYC=2.
- Scan order: digits 1,2,3,4,5,6 (hr_10..sec_1), edit_en=0 -> each digit has 2 blank cycles then 10 cycles with its anode low. Order is an[0] (sec_1=6, seg=7'h02), an[1], ..., an[5] (hr_10=1, seg=7'h79), then back to an[0]. dp=0 only during the idx 2 and idx 4 active windows.
- Cursor blink: edit_en=1, cursor=3, min_10=5 -> within the idx 3 window, seg=7'h12 while blink_phase=0 and seg=7'h7F while blink_phase=1, toggling every 60 cycles. Other digits are unaffected. With cursor=7, no digit ever blanks.
- Invalid BCD: sec_10=4'hC -> during the idx 1 window seg=7'h3F.
- Async reset: assert reset mid-dwell at idx 3, between clock edges -> an=6'b111111, seg=7'h7F, dp=1 with no clock edge. After release, the first cycle is guard and idx 0 is active from cycle 3.
- LEADING_ZERO_BLANK_EN: hr_10=0 -> idx 5 window blank. With edit_en=1 and cursor=5, seg=7'h40 during the blink-on phase. Without the macro, seg=7'h40 always.
